// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN stream sequencer and the register file.
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } cnn_seq_state_t;

    // A 3x3 kernel needs at least a 3x3 image to produce any result
    localparam int unsigned MIN_DIM = 3;

    localparam logic [7:0] REG_CTRL_ADDR     = 8'h00;
    localparam logic [7:0] REG_STATUS_ADDR   = 8'h04;
    localparam logic [7:0] REG_IN_BASE_ADDR  = 8'h08;
    localparam logic [7:0] REG_OUT_BASE_ADDR = 8'h0C;
    localparam logic [7:0] REG_IMG_SIZE_ADDR = 8'h10;

endpackage

// File: rtl/cnn_result_fifo.sv
// Small synchronous FIFO holding datapath results until the memory port is free.
module cnn_result_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clr_i,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         push_data_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         pop_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]        count_reg, count_next;
    logic [DATA_WIDTH-1:0] entry_data [FIFO_DEPTH];
    logic                  do_push, do_pop;

    assign full_o  = (count_reg == DEPTH_C);
    assign empty_o = (count_reg == '0);
    assign count_o = count_reg;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + (PTR_W+1)'(1);
        end else if (!do_push && do_pop) begin
            count_next = count_reg - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : gen_entry
            logic [DATA_WIDTH-1:0] entry_reg;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    entry_reg <= '0;
                end else if (do_push && wr_ptr_reg == PTR_W'(gi)) begin
                    entry_reg <= push_data_i;
                end
            end
            assign entry_data[gi] = entry_reg;
        end
    endgenerate

    assign pop_data_o = entry_data[rd_ptr_reg];

endmodule

// File: rtl/cnn_stream_sequencer.sv
// Frame controller: streams pixels from memory into the datapath and writes
// results back, sharing one memory port with writes taking priority.
module cnn_stream_sequencer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DIM_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] input_base_i,
    input  logic [ADDR_WIDTH-1:0] output_base_i,
    input  logic [DIM_WIDTH-1:0]  img_w_i,
    input  logic [DIM_WIDTH-1:0]  img_h_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cfg_err_o,
    output logic [DATA_WIDTH-1:0] pixel_o,
    output logic                  pixel_valid_o,
    input  logic [DATA_WIDTH-1:0] result_i,
    input  logic                  result_valid_i,
    output logic                  result_ready_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_en_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  mem_wr_en_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o
);

    localparam int IDX_W = 2 * DIM_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]     DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [DIM_WIDTH-1:0] MIN_DIM_C = DIM_WIDTH'(MIN_DIM);

    cnn_seq_state_t        state_reg, state_next;
    logic [ADDR_WIDTH-1:0] in_base_reg, out_base_reg;
    logic [IDX_W-1:0]      total_reg, expected_reg;
    logic [IDX_W-1:0]      rd_idx_reg, rd_idx_next, wr_idx_reg, wr_idx_next;
    logic                  pixel_valid_reg, cfg_err_reg, cfg_err_next;
    logic                  active, wr_grant, rd_grant, start_ok, fifo_clr;
    logic                  fifo_push, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]      fifo_count;

    assign active   = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign wr_grant = active && !fifo_empty;
    assign rd_grant = !wr_grant && (state_reg == ST_RUN) && (rd_idx_reg < total_reg);

    assign rd_idx_next = rd_idx_reg + IDX_W'(rd_grant);
    assign wr_idx_next = wr_idx_reg + IDX_W'(wr_grant);

    assign mem_wr_en_o = wr_grant;
    assign mem_rd_en_o = rd_grant;
    assign mem_addr_o  = wr_grant ? out_base_reg + ADDR_WIDTH'(wr_idx_reg) :
                         rd_grant ? in_base_reg + ADDR_WIDTH'(rd_idx_reg) : '0;
    assign mem_wdata_o = wr_grant ? fifo_head : '0;

    // Ready follows the registered count only; a same-cycle pop does not free a slot
    assign result_ready_o = (fifo_count < DEPTH_C);
    assign fifo_push      = active && result_valid_i && !fifo_full;

    always_comb begin
        state_next   = state_reg;
        start_ok     = 1'b0;
        fifo_clr     = 1'b0;
        cfg_err_next = 1'b0;
        if (state_reg != ST_IDLE && abort_i) begin
            state_next = ST_IDLE;
            fifo_clr   = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        if (img_w_i >= MIN_DIM_C && img_h_i >= MIN_DIM_C) begin
                            state_next = ST_RUN;
                            start_ok   = 1'b1;
                            fifo_clr   = 1'b1;
                        end else begin
                            cfg_err_next = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_idx_next == total_reg) state_next = ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Late results after the final write are discarded
                    if (wr_idx_next == expected_reg) begin
                        state_next = ST_DONE;
                        fifo_clr   = 1'b1;
                    end
                end
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= ST_IDLE;
            in_base_reg     <= '0;
            out_base_reg    <= '0;
            total_reg       <= '0;
            expected_reg    <= '0;
            rd_idx_reg      <= '0;
            wr_idx_reg      <= '0;
            pixel_valid_reg <= 1'b0;
            cfg_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cfg_err_reg     <= cfg_err_next;
            pixel_valid_reg <= rd_grant && !abort_i;
            if (start_ok) begin
                in_base_reg  <= input_base_i;
                out_base_reg <= output_base_i;
                total_reg    <= IDX_W'(img_w_i) * IDX_W'(img_h_i);
                expected_reg <= IDX_W'(img_w_i - DIM_WIDTH'(2)) * IDX_W'(img_h_i - DIM_WIDTH'(2));
                rd_idx_reg   <= '0;
                wr_idx_reg   <= '0;
            end else begin
                rd_idx_reg <= rd_idx_next;
                wr_idx_reg <= wr_idx_next;
            end
        end
    end

    assign busy_o        = active;
    assign done_o        = (state_reg == ST_DONE);
    assign cfg_err_o     = cfg_err_reg;
    assign pixel_valid_o = pixel_valid_reg;
    assign pixel_o       = pixel_valid_reg ? mem_rdata_i : '0;

    cnn_result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (fifo_clr),
        .push_i      (fifo_push),
        .push_data_i (result_i),
        .pop_i       (wr_grant),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_cnn_stream_sequencer.sv
// Randomized bench for cnn_stream_sequencer against a queue-based frame model.
module tb_cnn_stream_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] input_base_i = '0;
    logic [31:0] output_base_i = '0;
    logic [7:0]  img_w_i = '0;
    logic [7:0]  img_h_i = '0;
    logic        busy_o, done_o, cfg_err_o;
    logic [7:0]  pixel_o;
    logic        pixel_valid_o;
    logic [7:0]  result_i = '0;
    logic        result_valid_i = 1'b0;
    logic        result_ready_o;
    logic [31:0] mem_addr_o;
    logic        mem_rd_en_o;
    logic [7:0]  mem_rdata_i = '0;
    logic        mem_wr_en_o;
    logic [7:0]  mem_wdata_o;

    always #5 clk_i = ~clk_i;

    cnn_stream_sequencer #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (32),
        .DIM_WIDTH  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .input_base_i   (input_base_i),
        .output_base_i  (output_base_i),
        .img_w_i        (img_w_i),
        .img_h_i        (img_h_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .cfg_err_o      (cfg_err_o),
        .pixel_o        (pixel_o),
        .pixel_valid_o  (pixel_valid_o),
        .result_i       (result_i),
        .result_valid_i (result_valid_i),
        .result_ready_o (result_ready_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rd_en_o    (mem_rd_en_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_wr_en_o    (mem_wr_en_o),
        .mem_wdata_o    (mem_wdata_o)
    );

    // Image memory: pixel value is a fixed function of its address
    function automatic logic [7:0] pix_fn(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    always @(posedge clk_i) begin
        if (mem_rd_en_o) mem_rdata_i <= pix_fn(mem_addr_o);
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Frame model: phase 0 idle, 1 reading, 2 draining, 3 done
    int          m_state = 0;
    int          m_total = 0, m_exp = 0, m_rd = 0, m_wr = 0;
    logic [31:0] m_in = '0, m_out = '0;
    logic [7:0]  m_fifo[$];
    logic        m_pv = 1'b0, m_cfg = 1'b0;
    logic [31:0] m_pv_addr = '0;

    int          cyc = 0;
    int          start_cyc = 0, first_rd_cyc = -1, last_rd_cyc = 0, first_pv_cyc = -1;
    int          n_rd = 0, n_pv = 0, done_cyc = 0, done_cnt = 0, cfg_cnt = 0, last_wr_cyc = 0;
    logic [31:0] first_rd_addr = '0, last_rd_addr = '0;
    logic [31:0] wr_a[$];
    logic [7:0]  wr_d[$];

    always @(negedge clk_i) begin
        logic        e_act, e_wr, e_rd, do_push;
        logic [31:0] e_addr;
        logic [7:0]  e_wd, e_pix;
        cyc++;
        if (!rst_ni) begin
            m_state = 0; m_fifo.delete(); m_pv = 1'b0; m_cfg = 1'b0; m_rd = 0; m_wr = 0;
            chk("rst_busy", busy_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_cfg_err", cfg_err_o, 0);
            chk("rst_pixel_valid", pixel_valid_o, 0);
            chk("rst_pixel", pixel_o, 0);
            chk("rst_ready", result_ready_o, 1);
            chk("rst_rd_en", mem_rd_en_o, 0);
            chk("rst_wr_en", mem_wr_en_o, 0);
            chk("rst_addr", mem_addr_o, 0);
            chk("rst_wdata", mem_wdata_o, 0);
        end else begin
            e_act  = (m_state == 1) || (m_state == 2);
            e_wr   = e_act && (m_fifo.size() > 0);
            e_rd   = !e_wr && (m_state == 1) && (m_rd < m_total);
            e_addr = e_wr ? m_out + 32'(m_wr) : (e_rd ? m_in + 32'(m_rd) : 32'h0);
            e_wd   = e_wr ? m_fifo[0] : 8'h00;
            e_pix  = m_pv ? pix_fn(m_pv_addr) : 8'h00;

            chk("busy", busy_o, e_act);
            chk("done", done_o, m_state == 3);
            chk("cfg_err", cfg_err_o, m_cfg);
            chk("ready", result_ready_o, m_fifo.size() < 4);
            chk("wr_en", mem_wr_en_o, e_wr);
            chk("rd_en", mem_rd_en_o, e_rd);
            chk("strobe_excl", mem_wr_en_o & mem_rd_en_o, 0);
            chk("addr", mem_addr_o, e_addr);
            chk("wdata", mem_wdata_o, e_wd);
            chk("pixel_valid", pixel_valid_o, m_pv);
            chk("pixel", pixel_o, e_pix);

            if (e_rd) begin
                if (first_rd_cyc < 0) begin first_rd_cyc = cyc; first_rd_addr = e_addr; end
                last_rd_cyc = cyc; last_rd_addr = e_addr; n_rd++;
            end
            if (e_wr) begin wr_a.push_back(e_addr); wr_d.push_back(e_wd); last_wr_cyc = cyc; end
            if (m_pv) begin n_pv++; if (first_pv_cyc < 0) first_pv_cyc = cyc; end
            if (m_state == 3) begin done_cyc = cyc; done_cnt++; end
            if (m_cfg) cfg_cnt++;

            do_push   = e_act && result_valid_i && (m_fifo.size() < 4);
            m_pv      = e_rd && !abort_i;
            m_pv_addr = e_addr;
            m_cfg     = 1'b0;
            if (e_wr) begin void'(m_fifo.pop_front()); m_wr++; end
            if (do_push) m_fifo.push_back(result_i);
            if (e_rd) m_rd++;
            if (abort_i && m_state != 0) begin
                m_state = 0; m_fifo.delete();
            end else begin
                case (m_state)
                    0: if (start_i) begin
                        if (img_w_i >= 3 && img_h_i >= 3) begin
                            m_in = input_base_i; m_out = output_base_i;
                            m_total = int'(img_w_i) * int'(img_h_i);
                            m_exp = (int'(img_w_i) - 2) * (int'(img_h_i) - 2);
                            m_rd = 0; m_wr = 0; m_fifo.delete(); m_state = 1;
                            start_cyc = cyc; first_rd_cyc = -1; first_pv_cyc = -1;
                            n_rd = 0; n_pv = 0; done_cnt = 0; wr_a.delete(); wr_d.delete();
                        end else begin
                            m_cfg = 1'b1;
                        end
                    end
                    1: if (m_rd == m_total) m_state = 2;
                    2: if (m_wr == m_exp) begin m_state = 3; m_fifo.delete(); end
                    default: m_state = 0;
                endcase
            end
        end
    end

    // Datapath emulation: 0 silent, 1 random, 2 back-to-back, 3 one 0x5A after 9 pixels
    int         res_mode = 0, res_left = 0, n_pix_drv = 0;
    logic       last_done = 1'b0;
    logic [7:0] sent_q[$];

    task automatic tick();
        logic acc;
        @(negedge clk_i);
        acc = result_valid_i && result_ready_o;
        if (pixel_valid_o) n_pix_drv++;
        last_done = done_o;
        @(posedge clk_i);
        #1;
        if (acc) begin sent_q.push_back(result_i); res_left--; result_valid_i = 1'b0; end
        if (!result_valid_i && res_left > 0) begin
            case (res_mode)
                1: if ($urandom_range(0, 1) == 1) begin result_valid_i = 1'b1; result_i = 8'($urandom); end
                2: begin result_valid_i = 1'b1; result_i = 8'($urandom); end
                3: if (n_pix_drv >= 9) begin result_valid_i = 1'b1; result_i = 8'h5A; end
                default: ;
            endcase
        end
    endtask

    task automatic start_frame(input int w, input int h, input logic [31:0] ib,
                               input logic [31:0] ob, input int mode);
        img_w_i = 8'(w); img_h_i = 8'(h); input_base_i = ib; output_base_i = ob;
        res_mode = mode; res_left = (w >= 3 && h >= 3) ? (w - 2) * (h - 2) : 0;
        sent_q.delete(); n_pix_drv = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k;
        k = 0; last_done = 1'b0;
        while (!last_done && k < budget) begin tick(); k++; end
        chk({nm, "_done_seen"}, last_done, 1);
        tick();
        res_mode = 0; res_left = 0; result_valid_i = 1'b0;
    endtask

    task automatic check_frame(input string nm, input int w, input int h, input logic [31:0] ob);
        chk({nm, "_nrd"}, n_rd, w * h);
        chk({nm, "_npix"}, n_pv, w * h);
        chk({nm, "_nwr"}, wr_a.size(), (w - 2) * (h - 2));
        for (int i = 0; i < wr_a.size(); i++) begin
            chk({nm, "_wr_addr"}, wr_a[i], ob + 32'(i));
            if (i < sent_q.size()) chk({nm, "_wr_order"}, wr_d[i], sent_q[i]);
        end
        $display("frame %s: %0dx%0d reads=%0d writes=%0d", nm, w, h, n_rd, wr_a.size());
    endtask

    initial begin
        int w, h, snap_rd, cfg0;
        logic [31:0] ib, ob;
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();

        // 3x3 single result
        start_frame(3, 3, 32'h100, 32'h200, 3);
        wait_done("t1", 60);
        check_frame("t1", 3, 3, 32'h200);
        chk("t1_first_rd_lat", first_rd_cyc - start_cyc, 1);
        chk("t1_first_pix_lat", first_pv_cyc - start_cyc, 2);
        chk("t1_last_rd_lat", last_rd_cyc - start_cyc, 9);
        chk("t1_first_rd_addr", first_rd_addr, 32'h100);
        chk("t1_last_rd_addr", last_rd_addr, 32'h108);
        chk("t1_wr_addr", wr_a[0], 32'h200);
        chk("t1_wr_data", wr_d[0], 32'h5A);
        chk("t1_done_lat", done_cyc - last_wr_cyc, 1);
        // result arriving while idle is discarded
        result_valid_i = 1'b1; result_i = 8'h77;
        tick();
        result_valid_i = 1'b0;
        repeat (2) tick();
        chk("t1_idle_nowr", wr_a.size(), 1);

        // 4x4 with back-to-back results
        start_frame(4, 4, 32'h100, 32'h200, 2);
        wait_done("t2", 100);
        check_frame("t2", 4, 4, 32'h200);
        chk("t2_last_rd_lat", last_rd_cyc - start_cyc, 20);
        chk("t2_done_lat", done_cyc - start_cyc, 22);

        // rejected configurations
        cfg0 = cfg_cnt;
        start_frame(2, 5, 32'h0, 32'h0, 0);
        tick();
        chk("t3_busy_after_err", busy_o, 0);
        start_frame(5, 2, 32'h0, 32'h0, 0);
        tick();
        chk("t3_cfg_cnt", cfg_cnt - cfg0, 2);

        // start while busy is ignored
        start_frame(5, 4, 32'h300, 32'h400, 1);
        repeat (5) tick();
        img_w_i = 8'd3; img_h_i = 8'd3; start_i = 1'b1;
        tick();
        start_i = 1'b0; img_w_i = 8'd5; img_h_i = 8'd4;
        wait_done("t3b", 200);
        check_frame("t3b", 5, 4, 32'h400);

        // abort mid-RUN
        start_frame(6, 6, 32'h500, 32'h600, 1);
        repeat (15) tick();
        abort_i = 1'b1; res_mode = 0; res_left = 0; result_valid_i = 1'b0;
        tick();
        abort_i = 1'b0;
        snap_rd = n_rd;
        repeat (6) tick();
        chk("t4_idle", busy_o, 0);
        chk("t4_no_done", done_cnt, 0);
        chk("t4_no_reads", n_rd, snap_rd);
        start_frame(3, 3, 32'h100, 32'h200, 2);
        wait_done("t4b", 60);
        check_frame("t4b", 3, 3, 32'h200);

        // reset mid-DRAIN
        start_frame(5, 5, 32'h700, 32'h800, 0);
        repeat (30) tick();
        chk("t5_in_drain", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("t5_rst_busy", busy_o, 0);
        chk("t5_rst_rd", mem_rd_en_o, 0);
        chk("t5_rst_addr", mem_addr_o, 0);
        chk("t5_rst_ready", result_ready_o, 1);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        start_frame(4, 4, 32'h100, 32'h200, 2);
        wait_done("t5b", 100);
        check_frame("t5b", 4, 4, 32'h200);

        // randomized frames, one with wrapping input base
        for (int f = 0; f < 8; f++) begin
            w  = $urandom_range(3, 9);
            h  = $urandom_range(3, 9);
            ib = (f == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0FFF_FF00);
            ob = $urandom & 32'h0FFF_FF00;
            start_frame(w, h, ib, ob, $urandom_range(1, 2));
            wait_done("rnd", w * h * 3 + 50);
            check_frame("rnd", w, h, ob);
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cnn_stream_sequencer.md
# cnn_stream_sequencer

Frame-level controller for the CNN accelerator datapath. On a start command it streams a full W×H 8-bit image from the shared user memory into the line-buffer/conv/ReLU chain, in row-major order. It collects the datapath's result stream in a small FIFO and writes each result back to the output buffer. Both directions share the single user memory port under a fixed-priority arbiter. It sits between the OBI register file (start/base/size config, done/busy status) and the datapath plus memory port.

## Interface
- DATA_WIDTH, 8: pixel and result width.
- ADDR_WIDTH, 32: memory address width.
- DIM_WIDTH, 8: width of the image width/height config fields.
- FIFO_DEPTH, 4: result FIFO entries (power of two, ≥2).

- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle start pulse from the register file.
- abort_i  in  1  level; cancel the current frame.
- input_base_i  in  ADDR_WIDTH  first pixel address.
- output_base_i  in  ADDR_WIDTH  first result address.
- img_w_i, img_h_i  in  DIM_WIDTH  image width and height; sampled at start.
- busy_o  out  1  high while a frame is in progress.
- done_o  out  1  one-cycle pulse when a frame completes.
- cfg_err_o  out  1  one-cycle pulse when a start is rejected.
- pixel_o  out  DATA_WIDTH  pixel to the line buffer.
- pixel_valid_o  out  1  pixel_o is valid this cycle (the datapath always accepts).
- result_i  in  DATA_WIDTH  datapath result.
- result_valid_i  in  1  result_i is valid.
- result_ready_o  out  1  the sequencer accepts result_i this cycle.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_rd_en_o  out  1  read strobe; data returns on mem_rdata_i one cycle later.
- mem_rdata_i  in  DATA_WIDTH  read data.
- mem_wr_en_o  out  1  write strobe; single-cycle write.
- mem_wdata_o  out  DATA_WIDTH  write data.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start_i with img_w_i ≥ 3 and img_h_i ≥ 3:
  - latch the bases and dimensions;
  - set the expected result count to (W−2)·(H−2);
  - clear the read index, write index and FIFO;
  - go to RUN.
- IDLE, start_i with img_w_i < 3 or img_h_i < 3: pulse cfg_err_o, stay in IDLE.
- start_i outside IDLE is ignored.
- Arbitration, each cycle in RUN or DRAIN:
  - FIFO non-empty → write: mem_addr_o = out_base + wr_idx, mem_wdata_o = FIFO head, pop, wr_idx++.
  - Otherwise, in RUN with rd_idx < W·H → read: mem_addr_o = in_base + rd_idx, rd_idx++.
  - Writes always win. Read and write strobes are never both high.
- Pixel return: pixel_valid_o and pixel_o = mem_rdata_i exactly one cycle after each mem_rd_en_o.
- RUN → DRAIN when the last read has issued (rd_idx reaches W·H).
- DRAIN → DONE when wr_idx reaches the expected count. Results arriving after that are accepted and discarded.
- DONE → IDLE after one cycle. done_o = 1 in DONE.
- busy_o = 1 in RUN and DRAIN.
- FIFO acceptance: result_ready_o = (count < FIFO_DEPTH), based on the registered count only. There is no same-cycle pop→ready pass-through.
- A push and a pop in the same cycle leave the count unchanged.
- Arithmetic: indices and counts are unsigned and 2·DIM_WIDTH bits wide. Address sums wrap modulo 2^ADDR_WIDTH.
- abort_i, any non-IDLE state:
  - go to IDLE next cycle;
  - flush the FIFO;
  - no done_o pulse;
  - drop any read still in flight (no pixel_valid_o for it).
- Asynchronous reset, including mid-frame, returns all state to IDLE.

## Timing
- Reset values:
  - all outputs 0, including pixel_o, mem_addr_o and mem_wdata_o;
  - state IDLE;
  - FIFO empty, so result_ready_o = 1 after reset.
- start_i sampled at cycle 0. RUN and the first mem_rd_en_o at cycle 1. First pixel_valid_o at cycle 2.
- Read throughput: 1 pixel/cycle when the FIFO is empty. Each write steals exactly one read slot.
- A result accepted at cycle t is written at t+1 at the earliest.
- done_o asserts the cycle after the final write.
- All outputs are registered except mem_* and result_ready_o, which are decoded combinationally from registered state.

## Structure
- Shared package cnn_pkg holds:
  - the state enum cnn_seq_state_t;
  - localparam MIN_DIM = 3;
  - the register-map address constants, shared with the register file.
- Sub-module cnn_result_fifo: synchronous FIFO with push, pop, full, empty and count, parameterized by DATA_WIDTH and FIFO_DEPTH.
- The arbiter, counters and FSM live in the top module.

## Test plan
- 3×3 frame, in_base 0x100, out_base 0x200, datapath returns 0x5A after the 9th pixel → reads 0x100–0x108 at cycles 1–9, one write of 0x5A to 0x200, done_o one cycle later.
- 4×4 frame with results arriving back-to-back → 16 reads and 4 writes to 0x200–0x203, never both strobes in one cycle, every write interleaved ahead of pending reads.
- result_valid_i held high with memory writes forced to lag (FIFO fills to 4) → result_ready_o low at count 4, no result lost or duplicated, order preserved.
- start_i with img_w_i = 2 → cfg_err_o pulse, busy_o stays 0; start_i while busy → ignored.
- abort_i mid-RUN with 2 results queued → IDLE next cycle, no further strobes or pixel_valid_o, no done_o; a new start then runs normally.
- rst_ni asserted mid-DRAIN → all outputs 0 immediately; the next frame completes correctly.
